// File: rtl/led_pattern_engine.sv
// LED pattern generator: static, blink, rotate and PWM-dim modes driven by a
// configuration word, with a registered LED enable vector and status word.
module led_pattern_engine #(
  parameter int unsigned TICK_DIV = 100800
) (
  input  logic        okClk,
  input  logic        rst_n,
  input  logic [31:0] cfg,
  output logic [7:0]  led_on,
  output logic [31:0] status
);

  localparam int unsigned TickW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [31:0]      r_cfg_q;
  logic [TickW-1:0] r_tick_cnt;
  logic [15:0]      r_step_cnt;
  logic             r_phase;
  logic [7:0]       r_rot;
  logic [7:0]       r_pwm_cnt;
  logic [15:0]      r_events;

  logic        w_reload;
  logic        w_tick;
  logic        w_expiry;
  logic [1:0]  w_mode;
  logic [7:0]  w_pattern;
  logic [7:0]  w_duty;
  logic [15:0] w_period;
  logic [7:0]  w_led;

  always_comb begin
    w_reload  = (cfg != r_cfg_q);
    w_mode    = r_cfg_q[9:8];
    w_pattern = r_cfg_q[7:0];
    w_duty    = r_cfg_q[23:16];
    w_period  = (r_cfg_q[31:16] == 16'd0) ? 16'd1 : r_cfg_q[31:16];
    w_tick    = (r_tick_cnt == TickW'(TICK_DIV - 1));
    w_expiry  = w_tick && (r_step_cnt == (w_period - 16'd1));
    w_led     = 8'd0;
    unique case (w_mode)
      2'b00:   w_led = w_pattern;
      2'b01:   w_led = r_phase ? 8'd0 : w_pattern;
      2'b10:   w_led = r_rot;
      default: w_led = (r_pwm_cnt < w_duty) ? w_pattern : 8'd0;
    endcase
  end

  // Outputs reflect the current state, so they trail state changes by one cycle.
  always_ff @(posedge okClk) begin
    if (!rst_n) begin
      r_cfg_q    <= 32'd0;
      r_tick_cnt <= '0;
      r_step_cnt <= 16'd0;
      r_phase    <= 1'b0;
      r_rot      <= 8'd0;
      r_pwm_cnt  <= 8'd0;
      r_events   <= 16'd0;
      led_on     <= 8'd0;
      status     <= 32'd0;
    end else begin
      led_on <= w_led;
      status <= {w_led, w_mode, r_phase, 5'd0, r_events};
      if (w_reload) begin
        r_cfg_q    <= cfg;
        r_tick_cnt <= '0;
        r_step_cnt <= 16'd0;
        r_phase    <= 1'b0;
        r_rot      <= cfg[7:0];
        r_pwm_cnt  <= 8'd0;
        r_events   <= 16'd0;
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TickW'(1);
        if (w_mode == 2'b11) begin
          r_step_cnt <= 16'd0;
          r_phase    <= 1'b0;
          if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (r_pwm_cnt == 8'hFF) r_events <= r_events + 16'd1;
          end
        end else if (w_expiry) begin
          r_step_cnt <= 16'd0;
          r_events   <= r_events + 16'd1;
          if (w_mode == 2'b01) r_phase <= ~r_phase;
          if (w_mode == 2'b10) r_rot <= {r_rot[6:0], r_rot[7]};
        end else if (w_tick) begin
          r_step_cnt <= r_step_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios plus random
// configurations, compared every cycle against a closed-form reference model.
module tb_led_pattern_engine;

  localparam int unsigned TD = 4;

  logic        okClk;
  logic        rst_n;
  logic [31:0] cfg;
  logic [7:0]  led_on;
  logic [31:0] status;

  int n_checks;
  int n_errors;

  // Model state: configuration in effect and edges elapsed since its load.
  logic [31:0] m_cfg;
  int          m_n;

  led_pattern_engine #(
    .TICK_DIV(TD)
  ) u_dut (
    .okClk (okClk),
    .rst_n (rst_n),
    .cfg   (cfg),
    .led_on(led_on),
    .status(status)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Status word implied by a configuration that has been loaded for n edges.
  function automatic logic [31:0] model_status(input logic [31:0] c, input int n);
    logic [1:0]  mode;
    logic [7:0]  pat;
    logic [7:0]  led;
    logic [15:0] dbl;
    logic        ph;
    int          p;
    int          t;
    int          e;
    int          ev;
    mode = c[9:8];
    pat  = c[7:0];
    p    = (c[31:16] == 16'd0) ? 1 : int'(c[31:16]);
    t    = n / TD;
    ph   = 1'b0;
    if (mode == 2'b11) begin
      led = ((t % 256) < int'(c[23:16])) ? pat : 8'd0;
      ev  = (t / 256) % 65536;
    end else begin
      e  = t / p;
      ev = e % 65536;
      if (mode == 2'b01) ph = e[0];
      dbl = {pat, pat} << (e % 8);
      case (mode)
        2'b00:   led = pat;
        2'b01:   led = ph ? 8'd0 : pat;
        default: led = dbl[15:8];
      endcase
    end
    return {led, mode, ph, 5'd0, ev[15:0]};
  endfunction

  task automatic step();
    logic [31:0] exp;
    logic        rst_s;
    logic [31:0] cfg_s;
    rst_s = rst_n;
    cfg_s = cfg;
    exp   = rst_s ? model_status(m_cfg, m_n) : 32'd0;
    @(posedge okClk);
    #1;
    check("led_on", {24'd0, led_on}, {24'd0, exp[31:24]});
    check("status", status, exp);
    if (!rst_s) begin
      m_cfg = 32'd0;
      m_n   = 0;
    end else if (cfg_s != m_cfg) begin
      m_cfg = cfg_s;
      m_n   = 0;
    end else begin
      m_n++;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  int lit;

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_cfg    = 32'd0;
    m_n      = 0;
    rst_n    = 1'b0;
    cfg      = 32'd0;
    run(3);
    check("reset_status", status, 32'd0);

    // Static
    rst_n = 1'b1;
    cfg   = 32'h0000_00A5;
    run(2);
    check("static_led", {24'd0, led_on}, 32'h0000_00A5);
    run(20);

    // Blink, P=2
    cfg = 32'h0002_01FF;
    run(30);

    // Rotate, P=1 then period field 0
    cfg = 32'h0001_0281;
    run(40);
    cfg = 32'h0000_0281;
    run(40);

    // PWM D=64: exactly a quarter of the cycles lit
    cfg = 32'h0040_030F;
    lit = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (led_on == 8'h0F) lit++;
    end
    check("pwm_lit_cycles", lit, 256);
    run(20);
    cfg = 32'h0000_030F;
    run(300);

    // Mid-blink reconfiguration
    cfg = 32'h0003_01C3;
    run(37);
    cfg = 32'h0000_0033;
    run(2);
    check("reload_led", {24'd0, led_on}, 32'h0000_0033);
    run(20);

    // Reserved bits alone force a reload
    cfg = 32'h0000_FC33;
    run(10);

    // One-cycle reset during rotate
    cfg = 32'h0001_0281;
    run(23);
    rst_n = 1'b0;
    run(1);
    check("midreset_status", status, 32'd0);
    rst_n = 1'b1;
    run(30);

    // Random configurations, occasional resets
    for (int s = 0; s < 40; s++) begin
      cfg = {16'($urandom_range(0, 3)), 6'($urandom), 2'($urandom), 8'($urandom)};
      if (cfg[9:8] == 2'b11) cfg[31:16] = 16'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 9) != 0);
      run(1);
      rst_n = 1'b1;
      run($urandom_range(1, 200));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
